hash_probe_ctrl: RTL
====================

# hash_probe_ctrl

Open-addressing hash-table controller that sits directly upstream of the 16K×14 distributed RAM. It is the only master of that RAM's `addr`/`din`/`we`/`dout` ports. It services lookup, insert and clear requests from the search core using linear probing. It returns hit/miss and a 2-bit value, one probe per cycle over the RAM's asynchronous read port.

## Interface
- `MAX_PROBE`, default 8: maximum slots examined per lookup/insert. Legal range 1..16384.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rstn`  in  1: reset. Synchronous and active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: high only in IDLE.
- `req_op`  in  2: 00 lookup, 01 insert, 10 clear, 11 reserved (answered with `rsp_err`).
- `req_key`  in  24: search key.
- `req_val`  in  2: insert value; 2'b11 is illegal.
- `rsp_valid`  out  1: one-cycle response pulse.
- `rsp_hit`  out  1: key fingerprint found (lookup/insert).
- `rsp_val`  out  2: stored value on lookup hit, else 0.
- `rsp_full`  out  1: `MAX_PROBE` exhausted with no match and no empty slot.
- `rsp_err`  out  1: illegal op or insert with `req_val`==2'b11.
- `ram_addr`  out  14: RAM address.
- `ram_din`  out  14: RAM write data.
- `ram_we`  out  1: RAM write enable.
- `ram_dout`  in  14: RAM read data, combinational from `ram_addr`.

## Operation
- Word format `{val[1:0], fp[11:0]}`. `val`==2'b11 marks an empty slot. Empty word is 0x3000.
- Fingerprint: `fp = key[23:12]`. Home slot: `home = key[13:0] ^ {key[23:14], 4'b0}`.
- Probe i (0-based) addresses `(home + i) mod 16384`; the address wraps from 0x3FFF to 0x0000.
- False hits are accepted by design: a different key with the same fp can sit in a probed slot.
- FSM states: IDLE → PROBE | CLEAR | RESP; PROBE → RESP; CLEAR → RESP; RESP → IDLE.
- IDLE:
  - Accept on `req_valid & req_ready`; latch op, key, val; clear the probe counter.
  - Op 11, or insert with val 11, goes straight to RESP with `rsp_err`=1 and no RAM access.
- PROBE, one slot per cycle, evaluating `ram_dout`:
  - Empty slot: a lookup ends as a miss. An insert writes `{val, fp}` on this edge and ends with `rsp_hit`=0.
  - `dout[11:0]`==fp and not empty: a lookup ends as a hit with `rsp_val`=`dout[13:12]`. An insert overwrites `{val, fp}` and ends with `rsp_hit`=1.
  - Otherwise, if i==`MAX_PROBE`-1, end with `rsp_full`=1 and no write; else i+1.
- CLEAR:
  - Write 0x3000 to address 0, 1, …, 16383, one per cycle, with `ram_we`=1.
  - After address 16383, go to RESP with all flags 0.
- RESP: `rsp_valid`=1 for one cycle with the flags latched in the ending cycle. There is no response backpressure.
- `ram_we` is high only on the insert-ending probe cycle and on CLEAR cycles.
- In IDLE and RESP, `ram_addr`=0 and `ram_din`=0.

## Timing
- Reset values: `req_ready`=1 (IDLE), `rsp_valid`=0, `rsp_hit`=0, `rsp_val`=0, `rsp_full`=0, `rsp_err`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0.
- Accept edge = cycle A. A request ending at probe k (k=0..`MAX_PROBE`-1) spends cycles A+1..A+1+k in PROBE. `rsp_valid` is high in cycle A+2+k.
- Error response: `rsp_valid` in cycle A+1.
- Clear: CLEAR for cycles A+1..A+16384, `rsp_valid` in cycle A+16385.
- `req_ready` returns to 1 in the cycle after `rsp_valid`. A request held valid is accepted then. Back-to-back throughput is one request per k+3 cycles.
- Reset mid-operation: the FSM returns to IDLE on the next edge with no further writes. An in-flight insert write occurs only if its ending edge precedes reset. RAM is never cleared by reset. An aborted clear leaves a partial table, and software must reissue the clear.

## Configuration
- `HASH_PROBE_STATS_EN` defined:
  - Adds output `stat_probes` (32 bits), incremented every PROBE cycle and saturating at 0xFFFFFFFF.
  - Adds output `stat_full` (16 bits), incremented on each `rsp_full` response and saturating.
  - Both counters reset to 0 on `rstn`=0 and also clear on a completed clear op.
- Undefined: neither port nor counter exists. All other behaviour is identical.

## Test plan
- Reset, clear, then lookup key 0xABC123 → `ram_we` high for exactly 16384 cycles; then lookup probes 0x2BD3 once and returns `rsp_hit`=0, `rsp_full`=0 at A+2.
- Insert key 0xABC123 val 01 → one write of 0x1ABC to 0x2BD3. Lookup of the same key → `rsp_hit`=1, `rsp_val`=01. Re-insert with val 10 → `rsp_hit`=1 and the word becomes 0x2ABC.
- Collision: insert 0x000005 val 00 (0x0000 @0x0005), then 0x004015 val 10 → probes 0x0005 then writes 0x2004 @0x0006, `rsp_valid` at A+3.
- Wrap: insert 0x003FFF val 00 (0x0003 @0x3FFF), then 0x007FEF val 01 → second probe addresses 0x0000 and writes 0x1007.
- Full: `MAX_PROBE`=2, insert 0x000005, 0x004015, 0x008025 → the third returns `rsp_full`=1 with no write. The third insert with `req_val`=11 instead → `rsp_err`=1 at A+1 with no RAM access.
- Reset mid-clear at cycle A+100 → next cycle `req_ready`=1, `ram_we`=0, no `rsp_valid`. Addresses 0..98 hold 0x3000. With stats enabled, counters read 0.

Source files
------------

// File: rtl/hash_probe_ctrl_if.sv
// Request/response and RAM port bundle for hash_probe_ctrl.
// The controller uses the slave view; the search core and RAM use the master view.
interface hash_probe_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [23:0] req_key;
  logic [1:0]  req_val;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [1:0]  rsp_val;
  logic        rsp_full;
  logic        rsp_err;
  logic [13:0] ram_addr;
  logic [13:0] ram_din;
  logic        ram_we;
  logic [13:0] ram_dout;

  modport slave (
    input  req_valid, req_op, req_key, req_val, ram_dout,
    output req_ready, rsp_valid, rsp_hit, rsp_val, rsp_full, rsp_err,
           ram_addr, ram_din, ram_we
  );

  modport master (
    output req_valid, req_op, req_key, req_val, ram_dout,
    input  req_ready, rsp_valid, rsp_hit, rsp_val, rsp_full, rsp_err,
           ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/hash_probe_ctrl.sv
// Linear-probing hash-table controller over a 16Kx14 async-read RAM (word = {val, fp}).
// Optional HASH_PROBE_STATS_EN adds saturating probe-cycle and full-response counters.
module hash_probe_ctrl #(
  parameter int MAX_PROBE = 8
) (
  input  logic              clk,
  input  logic              rstn,
  hash_probe_ctrl_if.slave  bus
`ifdef HASH_PROBE_STATS_EN
  ,
  output logic [31:0]       stat_probes,
  output logic [15:0]       stat_full
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_CLEAR, S_RESP} state_e;

  localparam logic [1:0]  OP_INSERT = 2'b01;
  localparam logic [1:0]  OP_CLEAR  = 2'b10;
  localparam logic [1:0]  OP_RSVD   = 2'b11;
  localparam logic [1:0]  VAL_EMPTY = 2'b11;
  localparam logic [13:0] LAST_PROBE = 14'(MAX_PROBE - 1);
  localparam logic [13:0] LAST_ADDR  = 14'h3FFF;

  state_e      state_q;
  logic [1:0]  op_q;
  logic [11:0] fp_q;
  logic [1:0]  val_q;
  logic [13:0] addr_q;
  logic [13:0] cnt_q;
  logic        hit_q;
  logic [1:0]  rval_q;
  logic        full_q;
  logic        err_q;

  logic slot_empty;
  logic slot_match;
  logic probe_end;
  logic is_insert;

  function automatic logic [13:0] home_slot(input logic [23:0] key);
    return key[13:0] ^ {key[23:14], 4'b0000};
  endfunction

  always_comb begin
    slot_empty = (bus.ram_dout[13:12] == VAL_EMPTY);
    slot_match = !slot_empty && (bus.ram_dout[11:0] == fp_q);
    probe_end  = slot_empty || slot_match;
    is_insert  = (op_q == OP_INSERT);
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_hit   = hit_q;
  assign bus.rsp_val   = rval_q;
  assign bus.rsp_full  = full_q;
  assign bus.rsp_err   = err_q;

  // Write enable is gated by rstn so a reset edge never commits a write.
  always_comb begin
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    bus.ram_we   = 1'b0;
    case (state_q)
      S_PROBE: begin
        bus.ram_addr = addr_q;
        bus.ram_din  = {val_q, fp_q};
        bus.ram_we   = rstn && is_insert && probe_end;
      end
      S_CLEAR: begin
        bus.ram_addr = addr_q;
        bus.ram_din  = 14'h3000;
        bus.ram_we   = rstn;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      rval_q  <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q   <= bus.req_op;
            fp_q   <= bus.req_key[23:12];
            val_q  <= bus.req_val;
            cnt_q  <= '0;
            addr_q <= (bus.req_op == OP_CLEAR) ? 14'h0000 : home_slot(bus.req_key);
            if (bus.req_op == OP_RSVD ||
                (bus.req_op == OP_INSERT && bus.req_val == VAL_EMPTY)) begin
              err_q   <= 1'b1;
              state_q <= S_RESP;
            end else if (bus.req_op == OP_CLEAR) begin
              state_q <= S_CLEAR;
            end else begin
              state_q <= S_PROBE;
            end
          end
        end
        S_PROBE: begin
          if (probe_end) begin
            hit_q   <= slot_match;
            rval_q  <= (!is_insert && slot_match) ? bus.ram_dout[13:12] : 2'b00;
            state_q <= S_RESP;
          end else if (cnt_q == LAST_PROBE) begin
            full_q  <= 1'b1;
            state_q <= S_RESP;
          end else begin
            cnt_q  <= cnt_q + 14'd1;
            addr_q <= addr_q + 14'd1;
          end
        end
        S_CLEAR: begin
          if (addr_q == LAST_ADDR) state_q <= S_RESP;
          else                     addr_q  <= addr_q + 14'd1;
        end
        S_RESP: begin
          hit_q   <= 1'b0;
          rval_q  <= '0;
          full_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef HASH_PROBE_STATS_EN
  logic [31:0] probes_q;
  logic [15:0] sfull_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      probes_q <= '0;
      sfull_q  <= '0;
    end else if (state_q == S_CLEAR && addr_q == LAST_ADDR) begin
      probes_q <= '0;
      sfull_q  <= '0;
    end else if (state_q == S_PROBE) begin
      if (probes_q != 32'hFFFF_FFFF) probes_q <= probes_q + 32'd1;
      if (!probe_end && cnt_q == LAST_PROBE && sfull_q != 16'hFFFF)
        sfull_q <= sfull_q + 16'd1;
    end
  end

  assign stat_probes = probes_q;
  assign stat_full   = sfull_q;
`endif

endmodule
